axi_lite_slave_regs: RTL and testbench

- AXI4-Lite slave endpoint. Consumes the shared AXI4-Lite types and response codes, and terminates a master's five channels into a bank of NUM_REGS 32-bit read/write registers.
- Sits directly downstream of any AXI4-Lite master or interconnect port.
- Drives register contents out to the fabric as a flat vector.
- Write and read channels run independently; one outstanding transaction per direction.

---
 rtl/axi_lite_slave_regs_pkg.sv | 22 ++
 rtl/axi_lite_slave_regs_if.sv | 26 ++
 rtl/axi_lite_slave_regs_wr_join.sv | 64 ++++++
 rtl/axi_lite_slave_regs.sv | 74 +++++++
 tb/tb_axi_lite_slave_regs.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_slave_regs_pkg.sv
// axi_lite_slave_regs_pkg: shared AXI4-Lite types, response codes and FSM states
package axi_lite_slave_regs_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB = 2;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0] resp_t;
    typedef logic [2:0] prot_t;
    localparam resp_t RESP_OKAY = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic data_t strb_merge(data_t old_data, data_t new_data, strb_t strb);
        data_t r;
        for (int b = 0; b < STRB_WIDTH; b++)
            r[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// axi_lite_slave_regs_if: AXI4-Lite five-channel bundle with master/slave views
interface axi_lite_slave_regs_if;
    import axi_lite_slave_regs_pkg::*;
    addr_t awaddr;
    prot_t awprot;
    logic awvalid, awready;
    data_t wdata;
    strb_t wstrb;
    logic wvalid, wready;
    resp_t bresp;
    logic bvalid, bready;
    addr_t araddr;
    prot_t arprot;
    logic arvalid, arready;
    data_t rdata;
    resp_t rresp;
    logic rvalid, rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regs_wr_join.sv
// axi_lite_wr_join: captures AW and W in any order, issues one joined write and owns the B channel
module axi_lite_wr_join
    import axi_lite_slave_regs_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic  aclk,
    input  logic  areset_n,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  strb_t wstrb,
    input  logic  wvalid,
    output logic  wready,
    output resp_t bresp,
    output logic  bvalid,
    input  logic  bready,
    output logic  wr_valid,
    output addr_t wr_addr,
    output data_t wr_data,
    output strb_t wr_strb
);
    wr_state_t state, state_n;
    logic live, aw_held, w_held, wr_hit;
    addr_t aw_q;
    data_t wd_q;
    strb_t ws_q;
    // live holds the readies low until the first edge after reset releases
    always_comb begin
        awready = live && state == W_IDLE && !aw_held;
        wready = live && state == W_IDLE && !w_held;
        bvalid = state == W_RESP;
        wr_addr = aw_held ? aw_q : awaddr;
        wr_data = w_held ? wd_q : wdata;
        wr_strb = w_held ? ws_q : wstrb;
        wr_valid = (aw_held || (awvalid && awready)) && (w_held || (wvalid && wready));
        wr_hit = wr_addr[ADDR_WIDTH-1:ADDR_LSB] < (ADDR_WIDTH-ADDR_LSB)'(NUM_REGS);
        state_n = wr_valid ? W_RESP : (bvalid && bready) ? W_IDLE : state;
    end
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= W_IDLE;
            live <= 1'b0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_q <= '0;
            wd_q <= '0;
            ws_q <= '0;
            bresp <= RESP_OKAY;
        end else begin
            state <= state_n;
            live <= 1'b1;
            aw_held <= !wr_valid && (aw_held || (awvalid && awready));
            w_held <= !wr_valid && (w_held || (wvalid && wready));
            if (awvalid && awready) aw_q <= awaddr;
            if (wvalid && wready) begin
                wd_q <= wdata;
                ws_q <= wstrb;
            end
            if (wr_valid) bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end
endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite slave terminating into NUM_REGS 32-bit registers
// Optional reg_wr_pulse output enabled by AXI_LITE_SLAVE_REGS_WR_PULSE_EN.
module axi_lite_slave_regs
    import axi_lite_slave_regs_pkg::*;
#(
    parameter int    NUM_REGS    = 8,
    parameter data_t RESET_VALUE = 32'h0
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    axi_lite_slave_regs_if.slave     bus,
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
`endif
    output logic [NUM_REGS*32-1:0]   reg_q
);
    localparam int IW = ADDR_WIDTH - ADDR_LSB;
    logic wr_valid, live, ar_hit, unused_bits;
    addr_t wr_addr;
    data_t wr_data, rd_word;
    strb_t wr_strb;
    logic [IW-1:0] wr_idx, ar_idx;
    rd_state_t rstate, rstate_n;
    axi_lite_wr_join #(.NUM_REGS(NUM_REGS)) u_wr_join (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(bus.awaddr), .awvalid(bus.awvalid), .awready(bus.awready),
        .wdata(bus.wdata), .wstrb(bus.wstrb), .wvalid(bus.wvalid), .wready(bus.wready),
        .bresp(bus.bresp), .bvalid(bus.bvalid), .bready(bus.bready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );
    assign unused_bits = ^{bus.awprot, bus.arprot, wr_addr[ADDR_LSB-1:0], bus.araddr[ADDR_LSB-1:0]};
    assign wr_idx = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx = bus.araddr[ADDR_WIDTH-1:ADDR_LSB];
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) reg_q <= {NUM_REGS{RESET_VALUE}};
        else
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_valid && wr_idx == IW'(i))
                    reg_q[i*32 +: 32] <= strb_merge(reg_q[i*32 +: 32], wr_data, wr_strb);
    end
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) reg_wr_pulse <= '0;
        else
            for (int i = 0; i < NUM_REGS; i++)
                reg_wr_pulse[i] <= wr_valid && wr_idx == IW'(i) && |wr_strb;
    end
`endif
    // rd_word samples the flops before this edge's write lands, so a same-edge read sees old data
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_idx == IW'(i)) rd_word = reg_q[i*32 +: 32];
        ar_hit = ar_idx < IW'(NUM_REGS);
        bus.arready = live && rstate == R_IDLE;
        bus.rvalid = rstate == R_DATA;
        rstate_n = (bus.arvalid && bus.arready) ? R_DATA : (bus.rvalid && bus.rready) ? R_IDLE : rstate;
    end
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rstate <= R_IDLE;
            live <= 1'b0;
            bus.rdata <= '0;
            bus.rresp <= RESP_OKAY;
        end else begin
            rstate <= rstate_n;
            live <= 1'b1;
            if (bus.arvalid && bus.arready) begin
                bus.rdata <= rd_word;
                bus.rresp <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: randomized and directed AXI4-Lite checks against an array model
module tb_axi_lite_slave_regs;
    import axi_lite_slave_regs_pkg::*;
    localparam int NR = 8;
    localparam data_t RV = 32'hA5A5_5A5A;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    logic [NR*32-1:0] reg_q;
    data_t model [NR];
    int n_checks = 0;
    int n_fail = 0;
    axi_lite_slave_regs_if bus ();
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
    logic [NR-1:0] pulse;
`endif
    axi_lite_slave_regs #(.NUM_REGS(NR), .RESET_VALUE(RV)) dut (
        .aclk(aclk), .areset_n(areset_n), .bus(bus),
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
        .reg_wr_pulse(pulse),
`endif
        .reg_q(reg_q)
    );
    always #5 aclk = ~aclk;

    function automatic data_t merge(data_t o, data_t n, strb_t s);
        data_t r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r = (r & ~(32'hFF << (8 * b))) | (n & (32'hFF << (8 * b)));
        return r;
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic bit is_hit(addr_t a);
        return (a >> 2) < NR;
    endfunction

    function automatic void model_write(addr_t a, data_t d, strb_t s);
        if (is_hit(a)) model[a >> 2] = merge(model[a >> 2], d, s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = RV;
    endtask

    task automatic axi_write(input addr_t a, input data_t d, input strb_t s, input int aw_lead,
                             input int w_lead, input int b_hold, output resp_t resp, output int lat,
                             output bit stable, output logic [NR-1:0] p0, output logic [NR-1:0] p1);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.bready = 1'b0;
        stable = 1; lat = -1; resp = 'x; p0 = '0; p1 = '0;
        while (!(aw_done && w_done) && cyc < 64) begin
            bus.awvalid = !aw_done && cyc >= aw_lead;
            bus.wvalid = !w_done && cyc >= w_lead;
            #1;
            hs_aw = bus.awvalid && bus.awready;
            hs_w = bus.wvalid && bus.wready;
            @(negedge aclk);
            aw_done |= hs_aw;
            w_done |= hs_w;
            cyc++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int k = 0; k < 16 && lat < 0; k++)
            if (bus.bvalid) lat = k;
            else @(negedge aclk);
        if (lat >= 0) begin
            resp = bus.bresp;
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
            p0 = pulse;
`endif
            for (int k = 0; k <= b_hold; k++) begin
                bus.bready = (k == b_hold);
                @(negedge aclk);
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
                if (k == 0) p1 = pulse;
`endif
                if (k < b_hold && (!bus.bvalid || bus.bresp !== resp || bus.awready || bus.wready))
                    stable = 0;
            end
            bus.bready = 1'b0;
            if (bus.bvalid) stable = 0;
        end
    endtask

    task automatic axi_read(input addr_t a, input int ar_lead, input int r_hold, output data_t d,
                            output resp_t resp, output int lat, output bit stable);
        bit done = 0, hs;
        int cyc = 0;
        bus.araddr = a; bus.rready = 1'b0;
        stable = 1; lat = -1; d = 'x; resp = 'x;
        while (!done && cyc < 64) begin
            bus.arvalid = cyc >= ar_lead;
            #1;
            hs = bus.arvalid && bus.arready;
            @(negedge aclk);
            done = hs;
            cyc++;
        end
        bus.arvalid = 1'b0;
        for (int k = 0; k < 16 && lat < 0; k++)
            if (bus.rvalid) lat = k;
            else @(negedge aclk);
        if (lat >= 0) begin
            d = bus.rdata;
            resp = bus.rresp;
            for (int k = 0; k <= r_hold; k++) begin
                bus.rready = (k == r_hold);
                @(negedge aclk);
                if (k < r_hold && (!bus.rvalid || bus.rdata !== d || bus.rresp !== resp || bus.arready))
                    stable = 0;
            end
            bus.rready = 1'b0;
            if (bus.rvalid) stable = 0;
        end
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        n_checks++;
        if ({bus.bresp, bus.rresp, bus.rdata} !== {RESP_OKAY, RESP_OKAY, 32'h0}) begin
            n_fail++; $display("FAIL reset_resp: got %h/%h/%h want 0/0/0", bus.bresp, bus.rresp, bus.rdata);
        end
        n_checks++;
        if (reg_q !== model_flat()) begin
            n_fail++; $display("FAIL reset_regs: got %h want %h", reg_q, model_flat());
        end
        areset_n = 1'b1;
        #1;
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            n_fail++; $display("FAIL ready_at_release: got %b want 000", {bus.awready, bus.wready, bus.arready});
        end
        @(negedge aclk);
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_edge: got %b want 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_basic();
        resp_t r; int lat; bit st; data_t d; logic [NR-1:0] p0, p1;
        axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat, st, p0, p1);
        model_write(32'h8, 32'hDEADBEEF, 4'hF);
        n_checks++;
        if (lat !== 0 || r !== RESP_OKAY) begin
            n_fail++; $display("FAIL basic_b: got lat %0d resp %h want lat 0 resp 0", lat, r);
        end
        n_checks++;
        if (reg_q[95:64] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL basic_reg2: got %h want deadbeef", reg_q[95:64]);
        end
        n_checks++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            n_fail++; $display("FAIL basic_ready_after_b: got %b want 11", {bus.awready, bus.wready});
        end
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
        n_checks++;
        if (p0 !== 8'h04 || p1 !== 8'h00) begin
            n_fail++; $display("FAIL basic_pulse: got %h/%h want 04/00", p0, p1);
        end
`endif
        axi_read(32'h8, 0, 0, d, r, lat, st);
        n_checks++;
        if (d !== 32'hDEADBEEF || r !== RESP_OKAY || lat !== 0) begin
            n_fail++; $display("FAIL basic_read: got %h resp %h lat %0d want deadbeef 0 0", d, r, lat);
        end
    endtask

    task automatic test_w_first();
        resp_t r; int lat; bit st; logic [NR-1:0] p0, p1;
        axi_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0, r, lat, st, p0, p1);
        model_write(32'h8, 32'h11223344, 4'b0101);
        n_checks++;
        if (lat !== 0 || r !== RESP_OKAY) begin
            n_fail++; $display("FAIL wfirst_b: got lat %0d resp %h want lat 0 resp 0", lat, r);
        end
        n_checks++;
        if (reg_q[95:64] !== 32'hDE22BE44 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL wfirst_reg2: got %h want de22be44", reg_q[95:64]);
        end
        axi_write(32'h14, 32'h0BAD_F00D, 4'hF, 0, 2, 0, r, lat, st, p0, p1);
        model_write(32'h14, 32'h0BAD_F00D, 4'hF);
        n_checks++;
        if (lat !== 0 || r !== RESP_OKAY || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL awfirst: got lat %0d resp %h regs %h want 0 0 %h", lat, r, reg_q, model_flat());
        end
    endtask

    task automatic test_miss();
        resp_t r; int lat; bit st; data_t d; logic [NR-1:0] p0, p1;
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, lat, st, p0, p1);
        n_checks++;
        if (r !== RESP_SLVERR || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL miss_write: got resp %h regs %h want 2 %h", r, reg_q, model_flat());
        end
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
        n_checks++;
        if (p0 !== 8'h00) begin
            n_fail++; $display("FAIL miss_pulse: got %h want 00", p0);
        end
`endif
        axi_read(32'h20, 0, 0, d, r, lat, st);
        n_checks++;
        if (d !== 32'h0 || r !== RESP_SLVERR) begin
            n_fail++; $display("FAIL miss_read: got %h resp %h want 0 resp 2", d, r);
        end
        axi_write(32'hC, 32'h1234_5678, 4'h0, 0, 0, 0, r, lat, st, p0, p1);
        n_checks++;
        if (r !== RESP_OKAY || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL strb0: got resp %h regs %h want 0 %h", r, reg_q, model_flat());
        end
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
        n_checks++;
        if (p0 !== 8'h00) begin
            n_fail++; $display("FAIL strb0_pulse: got %h want 00", p0);
        end
`endif
    endtask

    task automatic test_backpressure();
        resp_t r; int lat; bit st; data_t d; logic [NR-1:0] p0, p1;
        axi_write(32'h4, 32'hC0DE_0001, 4'hF, 0, 0, 5, r, lat, st, p0, p1);
        model_write(32'h4, 32'hC0DE_0001, 4'hF);
        n_checks++;
        if (st !== 1'b1 || r !== RESP_OKAY) begin
            n_fail++; $display("FAIL bp_write: got stable %b resp %h want 1 0", st, r);
        end
        axi_read(32'h4, 0, 5, d, r, lat, st);
        n_checks++;
        if (st !== 1'b1 || d !== model[1]) begin
            n_fail++; $display("FAIL bp_read: got stable %b data %h want 1 %h", st, d, model[1]);
        end
    endtask

    task automatic test_same_edge();
        resp_t wr, rr; int wl, rl; bit ws, rs; data_t d; logic [NR-1:0] p0, p1;
        axi_write(32'h0, 32'h1, 4'hF, 0, 0, 0, wr, wl, ws, p0, p1);
        model_write(32'h0, 32'h1, 4'hF);
        fork
            axi_write(32'h0, 32'h2, 4'hF, 0, 0, 0, wr, wl, ws, p0, p1);
            axi_read(32'h0, 0, 0, d, rr, rl, rs);
        join
        n_checks++;
        if (d !== 32'h1 || rl !== 0 || wl !== 0) begin
            n_fail++; $display("FAIL same_edge_read: got %h lat %0d/%0d want 1 lat 0/0", d, rl, wl);
        end
        model_write(32'h0, 32'h2, 4'hF);
        n_checks++;
        if (reg_q[31:0] !== 32'h2) begin
            n_fail++; $display("FAIL same_edge_reg0: got %h want 2", reg_q[31:0]);
        end
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
        n_checks++;
        if (p0 !== 8'h01 || p1 !== 8'h00) begin
            n_fail++; $display("FAIL same_edge_pulse: got %h/%h want 01/00", p0, p1);
        end
`endif
    endtask

    task automatic test_random();
        resp_t r; int lat; bit st; data_t d, dat; logic [NR-1:0] p0, p1, pe;
        addr_t a; strb_t s;
        for (int it = 0; it < 80; it++) begin
            a = ($urandom_range(0, 5) == 0) ? $urandom() : addr_t'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                dat = $urandom();
                s = strb_t'($urandom_range(0, 15));
                axi_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, lat, st, p0, p1);
                model_write(a, dat, s);
                n_checks++;
                if (r !== (is_hit(a) ? RESP_OKAY : RESP_SLVERR) || lat !== 0 || st !== 1'b1 || reg_q !== model_flat()) begin
                    n_fail++; $display("FAIL rand_write a=%h: got resp %h lat %0d stable %b regs %h want regs %h",
                        a, r, lat, st, reg_q, model_flat());
                end
                pe = (is_hit(a) && s != 0) ? NR'(1) << (a >> 2) : '0;
`ifdef AXI_LITE_SLAVE_REGS_WR_PULSE_EN
                n_checks++;
                if (p0 !== pe || p1 !== 8'h00) begin
                    n_fail++; $display("FAIL rand_pulse a=%h: got %h/%h want %h/00", a, p0, p1, pe);
                end
`endif
            end else begin
                axi_read(a, $urandom_range(0, 3), $urandom_range(0, 2), d, r, lat, st);
                n_checks++;
                if (d !== (is_hit(a) ? model[a >> 2] : 32'h0) || r !== (is_hit(a) ? RESP_OKAY : RESP_SLVERR) ||
                    lat !== 0 || st !== 1'b1) begin
                    n_fail++; $display("FAIL rand_read a=%h: got %h resp %h lat %0d stable %b want %h",
                        a, d, r, lat, st, is_hit(a) ? model[a >> 2] : 32'h0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_b = 0;
        @(negedge aclk);
        bus.awaddr = 32'h4; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 32'h4; bus.arvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n_checks++;
        if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
            n_fail++; $display("FAIL mid_setup: got %b want 11", {bus.bvalid, bus.rvalid});
        end
        #2 areset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b0 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL mid_reset: got %b regs %h want 00000 %h",
                {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, reg_q, model_flat());
        end
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_fail++; $display("FAIL mid_release: got %b want 111", {bus.awready, bus.wready, bus.arready});
        end
        bus.awaddr = 32'hC; bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        n_checks++;
        if ({bus.awready, bus.wready} !== 2'b01) begin
            n_fail++; $display("FAIL aw_pending: got %b want 01", {bus.awready, bus.wready});
        end
        #2 areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.wvalid = 1'b0;
        repeat (3) begin
            seen_b |= bus.bvalid;
            @(negedge aclk);
        end
        n_checks++;
        if (seen_b !== 1'b0) begin
            n_fail++; $display("FAIL aw_discarded: got bvalid 1 want 0");
        end
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        model_write(32'h10, 32'hCAFE_F00D, 4'hF);
        n_checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL post_reset_write: got bvalid %b resp %h regs %h want 1 0 %h",
                bus.bvalid, bus.bresp, reg_q, model_flat());
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        test_reset();
        test_basic();
        test_w_first();
        test_miss();
        test_backpressure();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
